wave_gen_vpp: RTL and testbench
===============================

Name: wave_gen_vpp

Overview:
- Programmable test-waveform source for the DAC path. It is the stimulus-side counterpart of the peak-to-peak measurement on the ADC path.
- Emits one 12-bit sample per clk_sample cycle: square, triangle or sawtooth, swinging exactly between Min_set and Max_set.
- Emits either a fixed number of periods or runs continuously, so a known Vpp is driven through the circuit under test and measured on the return path.

Parameters:
- DW, 12, sample width (Max_set, Min_set, Step, Dataout)
- CW, 32, width of Hold, Times and the period counter

Ports:
- clk_sample  in   1   sample clock; one output sample per rising edge
- rst         in   1   asynchronous, active-high reset
- en          in   1   run request; level-sensitive
- mode        in   2   0 square, 1 triangle, 2 sawtooth, 3 DC (constant Min)
- Max_set     in   DW  upper level
- Min_set     in   DW  lower level
- Step        in   DW  ramp increment per sample (modes 1, 2)
- Hold        in   CW  samples per half-period (mode 0)
- Times       in   CW  periods to emit; 0 = continuous
- Dataout     out  DW  registered sample to DAC
- period_end  out  1   one-cycle pulse on the sample that completes a period
- done        out  1   high after Times periods emitted, until en drops
- cfg_err     out  1   configuration rejected

Behaviour:
- Reset (async, rst=1): state IDLE; Dataout=0, period_end=0, done=0, cfg_err=0; all counters and latched config cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE with en=1, config latch:
  - Latch mode, Max_set, Min_set, Step, Hold and Times.
  - Validity check: Max_set>Min_set; Step!=0 for modes 1/2; Hold!=0 for mode 0.
  - Invalid: stay IDLE, cfg_err=1, Dataout unchanged.
  - Valid: go RUN, cfg_err=0. The first sample, Dataout=Min, appears on the clock edge that performs the latch (1-cycle latency).
- Config inputs are ignored in RUN and DONE; changes take effect only through IDLE.
- en=0 in any state: next edge goes to IDLE; Dataout=latched Min; period_end=0; done=0; cfg_err=0; period counter cleared.
- Square (mode 0):
  - Max for Hold samples, then Min for Hold samples, repeating. The first half-period starts at Max on the latch edge.
  - period_end on the last Min sample.
- Triangle (mode 1):
  - Starts at Min, direction up.
  - Up: next=cur+Step, computed in DW+1 bits. If next>=Max, output Max and switch direction to down.
  - Down: if cur<=Min+Step (DW+1 bits), output Min, switch direction to up, and assert period_end. Otherwise output cur-Step.
  - The initial Min sample is not a period end.
- Sawtooth (mode 2):
  - Up ramp as in triangle, clamped to Max.
  - period_end on the Max sample; the next sample is Min.
- DC (mode 3): Dataout=Min constantly. period_end every Hold samples if Hold!=0; never if Hold=0. Hold=0 is valid in this mode.
- Period counter: increments on each period_end, compared against Times.
  - When the count reaches Times (Times!=0), go to DONE on that same edge; the last period_end pulse still fires.
  - Next edge: Dataout=Min, done=1. Hold in DONE until en=0.
- Times=0: run until en=0; the period counter wraps modulo 2^CW with no side effect.
- No overflow wrap: the up-clamp uses DW+1-bit sums, so Max=4095 with a large Step never wraps past 0.
- Mid-run reset: Dataout=0 immediately (asynchronously); restart requires a new IDLE→RUN transition.

Test Plan:
- Triangle, Min=100, Max=130, Step=10, Times=0:
  - Dataout = 100,110,120,130,120,110,100,110,…
  - period_end high only on the second and later 100 samples.
- Sawtooth, Min=0, Max=25, Step=10, Times=2:
  - Dataout = 0,10,20,25,0,10,20,25, then 0 held.
  - period_end on both 25 samples; done=1 after the second, stays 1 until en=0.
- Square, Max=4000, Min=96, Hold=3:
  - Dataout = 4000×3, 96×3, repeating.
  - period_end on every 6th sample.
- Overflow corner, Min=0, Max=4095, Step=4000, triangle:
  - Dataout = 0,4000,4095,95,0.
  - No value wraps below Min or above Max.
- Invalid config, Max_set=50, Min_set=60, en=1:
  - cfg_err=1, state stays IDLE, Dataout unchanged.
  - Correcting to Max_set=70 and pulsing en low then high starts RUN.
- Assert rst mid-RUN and en=0 mid-RUN:
  - rst: Dataout=0 asynchronously, done=0.
  - en=0: Dataout=Min on the next edge, counter cleared.
  - Re-enable: restarts from Min.

Source files
------------

// File: rtl/wave_gen_vpp.sv
// wave_gen_vpp: programmable square / triangle / sawtooth / DC sample source
// for the DAC path. The swing runs exactly between the latched Min and Max.
// It emits either a fixed number of periods or runs continuously.
module wave_gen_vpp #(
    parameter int DW = 12,
    parameter int CW = 32
) (
    input  logic          clk_sample,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] Max_set,
    input  logic [DW-1:0] Min_set,
    input  logic [DW-1:0] Step,
    input  logic [CW-1:0] Hold,
    input  logic [CW-1:0] Times,
    output logic [DW-1:0] Dataout,
    output logic          period_end,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] MODE_SQ  = 2'd0;
    localparam logic [1:0] MODE_TRI = 2'd1;
    localparam logic [1:0] MODE_SAW = 2'd2;
    localparam logic [1:0] MODE_DC  = 2'd3;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] step_q, step_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] times_q, times_d;
    logic [DW-1:0] data_q, data_d;
    logic          pe_q, pe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dir_q, dir_d;      // triangle direction: 1 = going down
    logic          phase_q, phase_d;  // square half: 1 = low (Min) half
    logic [CW-1:0] cnt_q, cnt_d;      // samples emitted in current hold window
    logic [CW-1:0] per_q, per_d;      // completed periods

    // Ramp arithmetic is done one bit wider so a large Step cannot wrap.
    logic [DW:0]   up_sum;
    logic [DW:0]   down_lim;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] per_next;
    logic          cfg_ok;

    assign up_sum   = {1'b0, data_q} + {1'b0, step_q};
    assign down_lim = {1'b0, min_q} + {1'b0, step_q};
    assign cnt_next = (cnt_q == hold_q) ? CW'(1) : cnt_q + CW'(1);
    assign per_next = per_q + CW'(1);

    // Validity of the live configuration inputs, judged at the latch edge.
    always_comb begin
        cfg_ok = (Max_set > Min_set);
        if ((mode == MODE_TRI || mode == MODE_SAW) && Step == '0) cfg_ok = 1'b0;
        if (mode == MODE_SQ && Hold == '0) cfg_ok = 1'b0;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            max_q   <= '0;
            min_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            times_q <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            max_q   <= max_d;
            min_q   <= min_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            times_q <= times_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
        end
    end

    // Next-state, waveform sample and period bookkeeping.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        max_d   = max_q;
        min_d   = min_q;
        step_d  = step_q;
        hold_d  = hold_q;
        times_d = times_q;
        data_d  = data_q;
        pe_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dir_d   = dir_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        per_d   = per_q;

        if (!en) begin
            state_d = IDLE;
            data_d  = min_q;
            per_d   = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_d  = mode;
                    max_d   = Max_set;
                    min_d   = Min_set;
                    step_d  = Step;
                    hold_d  = Hold;
                    times_d = Times;
                    if (cfg_ok) begin
                        state_d = RUN;
                        dir_d   = 1'b0;
                        phase_d = 1'b0;
                        cnt_d   = CW'(1);
                        per_d   = '0;
                        data_d  = (mode == MODE_SQ) ? Max_set : Min_set;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                RUN: begin
                    case (mode_q)
                        MODE_SQ: begin
                            cnt_d = cnt_next;
                            if (cnt_q == hold_q) phase_d = ~phase_q;
                            data_d = phase_d ? min_q : max_q;
                            pe_d   = phase_d && (cnt_next == hold_q);
                        end
                        MODE_TRI: begin
                            if (!dir_q) begin
                                if (up_sum >= {1'b0, max_q}) begin
                                    data_d = max_q;
                                    dir_d  = 1'b1;
                                end else begin
                                    data_d = up_sum[DW-1:0];
                                end
                            end else begin
                                if ({1'b0, data_q} <= down_lim) begin
                                    data_d = min_q;
                                    dir_d  = 1'b0;
                                    pe_d   = 1'b1;
                                end else begin
                                    data_d = data_q - step_q;
                                end
                            end
                        end
                        MODE_SAW: begin
                            if (data_q == max_q) begin
                                data_d = min_q;
                            end else if (up_sum >= {1'b0, max_q}) begin
                                data_d = max_q;
                                pe_d   = 1'b1;
                            end else begin
                                data_d = up_sum[DW-1:0];
                            end
                        end
                        default: begin
                            data_d = min_q;
                            if (hold_q != '0) begin
                                cnt_d = cnt_next;
                                pe_d  = (cnt_next == hold_q);
                            end
                        end
                    endcase
                    if (pe_d) begin
                        per_d = per_next;
                        if (times_q != '0 && per_next == times_q) state_d = DONE;
                    end
                end
                default: begin
                    data_d = min_q;
                    done_d = 1'b1;
                end
            endcase
        end
    end

    assign Dataout    = data_q;
    assign period_end = pe_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_wave_gen_vpp.sv
// Testbench for wave_gen_vpp: a table of directed vectors with hand-computed
// samples, followed by hand-written sequences for the asynchronous reset and
// for configuration changes made while running.
module tb_wave_gen_vpp;

   localparam int DW = 12;
   localparam int CW = 32;

   logic          clk_sample;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic [DW-1:0] Max_set;
   logic [DW-1:0] Min_set;
   logic [DW-1:0] Step;
   logic [CW-1:0] Hold;
   logic [CW-1:0] Times;
   logic [DW-1:0] Dataout;
   logic          period_end;
   logic          done;
   logic          cfg_err;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic          en;
      logic [1:0]    mode;
      logic [DW-1:0] maxSet;
      logic [DW-1:0] minSet;
      logic [DW-1:0] step;
      logic [CW-1:0] hold;
      logic [CW-1:0] times;
      logic [DW-1:0] expData;
      logic          expPe;
      logic          expDone;
      logic          expErr;
   } vec_t;

   vec_t vecs[$];

   wave_gen_vpp #(.DW(DW), .CW(CW)) dut (
      .clk_sample(clk_sample),
      .rst(rst),
      .en(en),
      .mode(mode),
      .Max_set(Max_set),
      .Min_set(Min_set),
      .Step(Step),
      .Hold(Hold),
      .Times(Times),
      .Dataout(Dataout),
      .period_end(period_end),
      .done(done),
      .cfg_err(cfg_err)
   );

   // Free-running sample clock, rising edges at 5, 15, 25 ...
   initial begin
      clk_sample = 1'b0;
      forever #5 clk_sample = ~clk_sample;
   end

   // Appends one vector (inputs for the next edge, outputs expected after it).
   task automatic addVec(input logic e, input logic [1:0] m, input int mx, input int mn,
                         input int st, input int hd, input int tm,
                         input int d, input logic p, input logic dn, input logic er);
      vec_t v;
      v.en = e; v.mode = m; v.maxSet = DW'(mx); v.minSet = DW'(mn); v.step = DW'(st);
      v.hold = CW'(hd); v.times = CW'(tm);
      v.expData = DW'(d); v.expPe = p; v.expDone = dn; v.expErr = er;
      vecs.push_back(v);
   endtask

   // Compares all four outputs against the expected values.
   task automatic checkOutput(input string name, input logic [DW-1:0] d, input logic p,
                              input logic dn, input logic er);
      checkCount++;
      if (Dataout !== d || period_end !== p || done !== dn || cfg_err !== er) begin
         errorCount++;
         $display("[TB] FAIL %s: got data=%0d pe=%0b done=%0b err=%0b, expected data=%0d pe=%0b done=%0b err=%0b",
                  name, Dataout, period_end, done, cfg_err, d, p, dn, er);
      end
   endtask

   // Drives one vector on the falling edge and checks just after the rising edge.
   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk_sample);
      en = v.en; mode = v.mode; Max_set = v.maxSet; Min_set = v.minSet;
      Step = v.step; Hold = v.hold; Times = v.times;
      @(posedge clk_sample);
      #1;
      checkOutput($sformatf("vec%0d", idx), v.expData, v.expPe, v.expDone, v.expErr);
   endtask

   // Sets all configuration inputs at once for the hand-written sequences.
   task automatic setCfg(input logic e, input logic [1:0] m, input int mx, input int mn,
                         input int st, input int hd, input int tm);
      en = e; mode = m; Max_set = DW'(mx); Min_set = DW'(mn); Step = DW'(st);
      Hold = CW'(hd); Times = CW'(tm);
   endtask

   // Main test: reset check, vector table, then multi-cycle corner sequences.
   initial begin
      // Triangle 100..130 step 10, continuous
      for (int i = 0; i < 8; i++) begin
         int tri_d[8] = '{100, 110, 120, 130, 120, 110, 100, 110};
         addVec(1, 1, 130, 100, 10, 0, 0, tri_d[i], i == 6, 0, 0);
      end
      addVec(0, 1, 130, 100, 10, 0, 0, 100, 0, 0, 0);
      // Sawtooth 0..25 step 10, two periods then DONE
      for (int i = 0; i < 10; i++) begin
         int saw_d[10] = '{0, 10, 20, 25, 0, 10, 20, 25, 0, 0};
         addVec(1, 2, 25, 0, 10, 0, 2, saw_d[i], i == 3 || i == 7, i >= 8, 0);
      end
      addVec(0, 2, 25, 0, 10, 0, 2, 0, 0, 0, 0);
      // Square 4000/96 hold 3
      for (int i = 0; i < 8; i++) begin
         addVec(1, 0, 4000, 96, 0, 3, 0, (i >= 3 && i <= 5) ? 96 : 4000, i == 5, 0, 0);
      end
      addVec(0, 0, 4000, 96, 0, 3, 0, 96, 0, 0, 0);
      // Triangle overflow corner: 0..4095 step 4000
      for (int i = 0; i < 6; i++) begin
         int ovf_d[6] = '{0, 4000, 4095, 95, 0, 4000};
         addVec(1, 1, 4095, 0, 4000, 0, 0, ovf_d[i], i == 4, 0, 0);
      end
      addVec(0, 1, 4095, 0, 4000, 0, 0, 0, 0, 0, 0);
      // Invalid Max<Min, then corrected via en low pulse
      addVec(1, 1, 50, 60, 5, 0, 0, 0, 0, 0, 1);
      addVec(1, 1, 50, 60, 5, 0, 0, 0, 0, 0, 1);
      addVec(0, 1, 70, 60, 5, 0, 0, 60, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         int fix_d[5] = '{60, 65, 70, 65, 60};
         addVec(1, 1, 70, 60, 5, 0, 0, fix_d[i], i == 4, 0, 0);
      end
      addVec(0, 1, 70, 60, 5, 0, 0, 60, 0, 0, 0);
      // DC hold 2, two periods then DONE
      for (int i = 0; i < 6; i++) begin
         addVec(1, 3, 30, 20, 0, 2, 2, 20, i == 1 || i == 3, i >= 4, 0);
      end
      addVec(0, 3, 30, 20, 0, 2, 2, 20, 0, 0, 0);
      // Square with Hold=0 and sawtooth with Step=0 are rejected
      addVec(1, 0, 30, 20, 0, 0, 0, 20, 0, 0, 1);
      addVec(0, 0, 30, 20, 0, 0, 0, 20, 0, 0, 0);
      addVec(1, 2, 30, 20, 0, 0, 0, 20, 0, 0, 1);
      addVec(0, 2, 30, 20, 0, 0, 0, 20, 0, 0, 0);
      // DC with Hold=0 is valid and never ends a period
      for (int i = 0; i < 4; i++) addVec(1, 3, 30, 20, 0, 0, 1, 20, 0, 0, 0);
      addVec(0, 3, 30, 20, 0, 0, 1, 20, 0, 0, 0);

      setCfg(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #3;
      checkOutput("reset_state", 0, 0, 0, 0);
      @(negedge clk_sample);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

      // Config changes while running are ignored
      @(negedge clk_sample);
      setCfg(1, 2, 25, 0, 10, 0, 0);
      @(posedge clk_sample); #1;
      checkOutput("cfg_hold_0", 0, 0, 0, 0);
      @(negedge clk_sample);
      Max_set = 12'd15; Step = 12'd1; Min_set = 12'd5;
      @(posedge clk_sample); #1;
      checkOutput("cfg_hold_1", 10, 0, 0, 0);
      @(posedge clk_sample); #1;
      checkOutput("cfg_hold_2", 20, 0, 0, 0);
      @(posedge clk_sample); #1;
      checkOutput("cfg_hold_3", 25, 1, 0, 0);
      @(negedge clk_sample);
      en = 1'b0;
      @(posedge clk_sample); #1;
      checkOutput("cfg_hold_stop", 0, 0, 0, 0);

      // Run a single sawtooth period to DONE, then reset asynchronously
      @(negedge clk_sample);
      setCfg(1, 2, 25, 5, 10, 0, 1);
      for (int i = 0; i < 4; i++) begin
         int rs_d[4] = '{5, 15, 25, 5};
         @(posedge clk_sample); #1;
         checkOutput($sformatf("rst_run%0d", i), rs_d[i], i == 2, i == 3, 0);
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async", 0, 0, 0, 0);
      @(negedge clk_sample);
      rst = 1'b0;
      setCfg(1, 1, 130, 100, 10, 0, 0);
      @(posedge clk_sample); #1;
      checkOutput("rst_restart0", 100, 0, 0, 0);
      @(posedge clk_sample); #1;
      checkOutput("rst_restart1", 110, 0, 0, 0);
      @(negedge clk_sample);
      en = 1'b0;
      @(posedge clk_sample); #1;
      checkOutput("en_drop", 100, 0, 0, 0);
      @(negedge clk_sample);
      en = 1'b1;
      @(posedge clk_sample); #1;
      checkOutput("en_restart", 100, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
